audio_i2s_tx: RTL and testbench

Stereo audio transmitter that sits downstream of the note-divider logic and drives the board's I2S stereo DAC. It has two jobs:
- Turn the per-ear half-period dividers into square-wave PCM samples, one per ear.
- Serialize each left/right sample pair onto the DAC pins MCLK/LRCK/SCK/SDIN.

All timing is derived from the 100 MHz system clock. No other clock domain exists.

---
 rtl/audio_i2s_tx.sv | 63 ++++++
 tb/tb_audio_i2s_tx.sv | 134 +++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: per-ear square-wave tone generators feeding a left-justified I2S serializer (clk/4 MCLK, clk/16 SCK, clk/512 LRCK); optional AUDIO_VOLUME_EN adds a 3-bit volume port
module audio_i2s_tx #(
  parameter int          DIV_W = 22,
  parameter logic [15:0] AMP   = 16'h2000
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]       volume,
`endif
  input  logic [DIV_W-1:0] note_div_left,
  input  logic [DIV_W-1:0] note_div_right,
  output logic             audio_mclk,
  output logic             audio_lrck,
  output logic             audio_sck,
  output logic             audio_sdin
);
  logic [8:0]       cnt;
  logic [DIV_W-1:0] div [2];
  logic [DIV_W-1:0] tcnt [2];
  logic [1:0]       ph;
  logic [15:0]      amp;
  logic [15:0]      smp [2];
  logic [31:0]      shreg;
  assign div[0] = note_div_left;
  assign div[1] = note_div_right;
`ifdef AUDIO_VOLUME_EN
  assign amp = (volume == 3'd0) ? 16'd0 : AMP >> (3'd7 - volume);
`else
  assign amp = AMP;
`endif
  always_comb begin
    for (int i = 0; i < 2; i++)
      smp[i] = (div[i] < DIV_W'(2)) ? 16'd0 : ph[i] ? amp : 16'(-amp);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      ph    <= '0;
      shreg <= '0;
      for (int i = 0; i < 2; i++)
        tcnt[i] <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (div[i] < DIV_W'(2)) begin
          tcnt[i] <= '0;
          ph[i]   <= 1'b0;
        end else if (tcnt[i] >= div[i] - DIV_W'(1)) begin
          tcnt[i] <= '0;
          ph[i]   <= ~ph[i];
        end else begin
          tcnt[i] <= tcnt[i] + 1'b1;
        end
      end
      shreg <= (&cnt) ? {smp[0], smp[1]} : (cnt[3:0] == 4'hf) ? {shreg[30:0], 1'b0} : shreg;
    end
  end
  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];
  assign audio_sdin = shreg[31];
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] note_div_left = '0;
  logic [21:0] note_div_right = '0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;
`ifdef AUDIO_VOLUME_EN
  logic [2:0]  volume = 3'd7;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon = 1'b0;
  int ratio_err = 0;
  int sdin_err = 0;
  logic prev_sck = 1'b0;
  logic prev_sdin = 1'b0;
  logic [31:0] w;
  int ph_err;

  audio_i2s_tx dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AUDIO_VOLUME_EN
    .volume(volume),
`endif
    .note_div_left(note_div_left),
    .note_div_right(note_div_right),
    .audio_mclk(audio_mclk),
    .audio_lrck(audio_lrck),
    .audio_sck(audio_sck),
    .audio_sdin(audio_sdin)
  );

  always #5 clk = ~clk;

  // edges since reset release; equals the expected divider count
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (mon) begin
      if (audio_mclk !== cyc[1] || audio_sck !== cyc[3] || audio_lrck !== cyc[8])
        ratio_err++;
      if (audio_sdin !== prev_sdin && !(prev_sck === 1'b1 && audio_sck === 1'b0))
        sdin_err++;
    end
    prev_sck  = audio_sck;
    prev_sdin = audio_sdin;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // call at the load cycle (cyc%512==511); samples mid-bit for 32 SCK periods
  task automatic grab(output logic [31:0] word);
    word = '0;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      while (cyc % 16 != 8) @(negedge clk);
      word = {word[30:0], audio_sdin};
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_out_%0d", i), {28'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
      note_div_left  = 22'(5 + i * 3);
      note_div_right = 22'(7 + i);
    end
    note_div_left  = 22'd100;
    note_div_right = 22'd1;
    rst_n = 1'b1;
    mon   = 1'b1;
    to(1);   chk("mclk_c1", {31'd0, audio_mclk}, 32'd0);
    to(2);   chk("mclk_c2", {31'd0, audio_mclk}, 32'd1);
    to(99);  chk("ph_l_c99", {31'd0, dut.ph[0]}, 32'd0);
    to(100); chk("ph_l_c100", {31'd0, dut.ph[0]}, 32'd1);
    to(199); chk("ph_l_c199", {31'd0, dut.ph[0]}, 32'd1);
    to(200); chk("ph_l_c200", {31'd0, dut.ph[0]}, 32'd0);
    chk("ph_r_silent", {31'd0, dut.ph[1]}, 32'd0);
    to(255); chk("lrck_c255", {31'd0, audio_lrck}, 32'd0);
    to(256); chk("lrck_c256", {31'd0, audio_lrck}, 32'd1);
    to(511);  grab(w); chk("frame_hi_1", w, 32'h2000_0000);
    to(1023); grab(w); chk("frame_lo", w, 32'hE000_0000);
    to(1535); grab(w); chk("frame_hi_2", w, 32'h2000_0000);
    to(2047);
    chk("clk_ratios", 32'(ratio_err), 32'd0);
    chk("sdin_on_sck_fall", 32'(sdin_err), 32'd0);
    mon = 1'b0;
    to(2100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset", {28'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
    note_div_left = 22'd1000;
    @(negedge clk);
    rst_n = 1'b1;
    to(500);
    chk("drop_ph_before", {31'd0, dut.ph[0]}, 32'd0);
    note_div_left = 22'd10;
    to(501); chk("drop_ph_next", {31'd0, dut.ph[0]}, 32'd1);
    ph_err = 0;
    while (cyc < 700) begin
      @(negedge clk);
      if (dut.ph[0] !== (((cyc - 501) / 10) % 2 == 0)) ph_err++;
    end
    chk("drop_period_10", 32'(ph_err), 32'd0);
`ifdef AUDIO_VOLUME_EN
    rst_n = 1'b0;
    note_div_left = 22'd100;
    volume = 3'd4;
    @(negedge clk);
    rst_n = 1'b1;
    to(511);  grab(w); chk("vol4_hi", w, 32'h0400_0000);
    to(1023); grab(w); chk("vol4_lo", w, 32'hFC00_0000);
    volume = 3'd0;
    to(1535); grab(w); chk("vol0", w, 32'h0000_0000);
    volume = 3'd7;
    to(2047); grab(w); chk("vol7_lo", w, 32'hE000_0000);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
